// File: rtl/rbz_spi_cmd_master_if.sv
// rtl/rbz_spi_cmd_master_if.sv - request/SPI signal bundle for rbz_spi_cmd_master
interface rbz_spi_cmd_master_if #(
    parameter int MAX_BITS = 96
);
    logic                i_start;
    logic [6:0]          i_len;
    logic [MAX_BITS-1:0] i_data;
    logic                o_busy;
    logic                o_done;
    logic                o_csb;
    logic                o_sclk;
    logic                o_mosi;

    // SoC-side requester drives the payload and watches status and the bus
    modport master (
        output i_start, i_len, i_data,
        input  o_busy, o_done, o_csb, o_sclk, o_mosi
    );

    // The command master itself
    modport slave (
        input  i_start, i_len, i_data,
        output o_busy, o_done, o_csb, o_sclk, o_mosi
    );
endinterface

// File: rtl/rbz_spi_cmd_master.sv
// rtl/rbz_spi_cmd_master.sv - SPI mode-0 serialiser for raybox-zero slave ports (option RBZ_SPI_CMD_LSB_FIRST_EN)
module rbz_spi_cmd_master #(
    parameter int MAX_BITS = 96,
    parameter int CLK_DIV  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    rbz_spi_cmd_master_if.slave  bus
);
    localparam logic [6:0] MAX_LEN = 7'(MAX_BITS);
    localparam logic [7:0] H_LAST  = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t              state;
    logic [7:0]          hcnt;
    logic [6:0]          bcnt;
    logic [MAX_BITS-1:0] sreg;

    logic [6:0]          eff_len;
    logic [MAX_BITS-1:0] load_val;
    logic                first_bit;
    logic [MAX_BITS-1:0] shifted;
    logic                next_bit;
    logic                half_done;

    // Clamp length, pre-align the payload and pick the bit that follows the current one
    always_comb begin
        eff_len = (bus.i_len > MAX_LEN) ? MAX_LEN : bus.i_len;
`ifdef RBZ_SPI_CMD_LSB_FIRST_EN
        load_val  = bus.i_data;
        first_bit = bus.i_data[0];
        shifted   = sreg >> 1;
        next_bit  = sreg[1];
`else
        load_val  = bus.i_data << (MAX_LEN - eff_len);
        first_bit = load_val[MAX_BITS-1];
        shifted   = sreg << 1;
        next_bit  = sreg[MAX_BITS-2];
`endif
        half_done = (hcnt == H_LAST);
    end

    // Transaction FSM; every SPI pin and status flag is a flop so the slave sees no glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            hcnt        <= '0;
            bcnt        <= '0;
            sreg        <= '0;
            bus.o_busy  <= 1'b0;
            bus.o_done  <= 1'b0;
            bus.o_csb   <= 1'b1;
            bus.o_sclk  <= 1'b0;
            bus.o_mosi  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.o_done <= 1'b0;
                    hcnt       <= '0;
                    // A zero-length request is dropped without touching any output
                    if (bus.i_start && (eff_len != 7'd0)) begin
                        sreg       <= load_val;
                        bcnt       <= eff_len;
                        state      <= S_SETUP;
                        bus.o_busy <= 1'b1;
                        bus.o_csb  <= 1'b0;
                        bus.o_sclk <= 1'b0;
                        bus.o_mosi <= first_bit;
                    end
                end
                S_SETUP: begin
                    if (half_done) begin
                        hcnt       <= '0;
                        state      <= S_HIGH;
                        bus.o_sclk <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (half_done) begin
                        hcnt       <= '0;
                        state      <= S_LOW;
                        bus.o_sclk <= 1'b0;
                        bcnt       <= bcnt - 7'd1;
                        // Data moves on the falling edge so it is settled long before the next rise
                        if (bcnt != 7'd1) begin
                            sreg       <= shifted;
                            bus.o_mosi <= next_bit;
                        end
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                S_LOW: begin
                    if (half_done) begin
                        hcnt <= '0;
                        if (bcnt != 7'd0) begin
                            state      <= S_HIGH;
                            bus.o_sclk <= 1'b1;
                        end else begin
                            state      <= S_GAP;
                            bus.o_csb  <= 1'b1;
                            bus.o_mosi <= 1'b0;
                        end
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (half_done) begin
                        hcnt       <= '0;
                        state      <= S_IDLE;
                        bus.o_busy <= 1'b0;
                        bus.o_done <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    hcnt       <= '0;
                    bus.o_busy <= 1'b0;
                    bus.o_done <= 1'b0;
                    bus.o_csb  <= 1'b1;
                    bus.o_sclk <= 1'b0;
                    bus.o_mosi <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rbz_spi_cmd_master.sv
// tb/tb_rbz_spi_cmd_master.sv - directed vector bench for rbz_spi_cmd_master
module tb_rbz_spi_cmd_master;
    localparam int MB = 96;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rbz_spi_cmd_master_if #(.MAX_BITS(MB)) bus_a ();
    rbz_spi_cmd_master_if #(.MAX_BITS(MB)) bus_b ();

    rbz_spi_cmd_master #(.MAX_BITS(MB), .CLK_DIV(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    rbz_spi_cmd_master #(.MAX_BITS(MB), .CLK_DIV(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    logic m_busy, m_done, m_csb, m_sclk, m_mosi;

    always_comb begin
        if (cur == 0) begin
            m_busy = bus_a.o_busy; m_done = bus_a.o_done; m_csb = bus_a.o_csb;
            m_sclk = bus_a.o_sclk; m_mosi = bus_a.o_mosi;
        end else begin
            m_busy = bus_b.o_busy; m_done = bus_b.o_done; m_csb = bus_b.o_csb;
            m_sclk = bus_b.o_sclk; m_mosi = bus_b.o_mosi;
        end
    end

    typedef struct {
        int           sel;
        logic [6:0]   len;
        logic [MB-1:0] data;
        int           busy;
        int           csb;
        int           edges;
        logic [127:0] cap;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [6:0] ln, input logic [MB-1:0] d);
        if (cur == 0) begin
            bus_a.i_start = st; bus_a.i_len = ln; bus_a.i_data = d;
        end else begin
            bus_b.i_start = st; bus_b.i_len = ln; bus_b.i_data = d;
        end
    endtask

    task automatic start_frame(input logic [6:0] ln, input logic [MB-1:0] d);
        drive(1'b1, ln, d);
        @(negedge clk);
        drive(1'b0, ln, d);
    endtask

    // Expected capture order: MSB-first payload, or its bit reversal in the LSB-first build
    function automatic logic [127:0] order(input logic [127:0] d, input int ln);
        logic [127:0] r;
        r = '0;
`ifdef RBZ_SPI_CMD_LSB_FIRST_EN
        for (int i = 0; i < ln; i++) r[i] = d[ln-1-i];
`else
        r = d;
`endif
        return r;
    endfunction

    // Observe one frame from the current negedge until o_done, optionally injecting starts
    task automatic measure(input int budget, input int inj, input bit chain,
                           input logic [6:0] c_len, input logic [MB-1:0] c_data,
                           output int busy_c, output int csb_c, output int edges,
                           output logic [127:0] cap, output int viol, output int tail);
        logic prev_sclk, prev_mosi;
        bit   seen;
        busy_c = 0; csb_c = 0; edges = 0; cap = '0; viol = 0; tail = 0;
        prev_sclk = 1'b0; prev_mosi = 1'b0; seen = 0;
        for (int c = 0; c < budget; c++) begin
            if (c == inj)     drive(1'b1, 7'd8, '0);
            if (c == inj + 1) drive(1'b0, 7'd8, '0);
            if (m_busy) busy_c++;
            if (!m_csb) begin csb_c++; tail = 0; end else tail++;
            if (m_sclk && !prev_sclk) begin
                edges++;
                cap = {cap[126:0], m_mosi};
            end
            if (m_sclk && prev_sclk && (m_mosi != prev_mosi)) viol++;
            prev_sclk = m_sclk;
            prev_mosi = m_mosi;
            if (m_done) begin
                seen = 1;
                if (chain) drive(1'b1, c_len, c_data);
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL frame_timeout: got no o_done within %0d cycles", budget);
        end
    endtask

    int busy_c, csb_c, edges, viol, tail;
    logic [127:0] cap;
    bit any_busy, any_csb, any_done;

    initial begin
        vt[0] = '{0, 7'd8,   96'hA5,          36,  34,  8,  128'hA5};
        vt[1] = '{1, 7'd96,  {24{4'h5}},      194, 193, 96, 128'({24{4'h5}})};
        vt[2] = '{0, 7'd120, {MB{1'b1}},      388, 386, 96, 128'({96{1'b1}})};
        vt[3] = '{0, 7'd1,   96'h1,           8,   6,   1,  128'h1};
        vt[4] = '{1, 7'd8,   96'h01,          18,  17,  8,  128'h01};
        vt[5] = '{0, 7'd4,   96'hF3,          20,  18,  4,  128'h3};

        reset = 1'b1;
        bus_a.i_start = 1'b0; bus_a.i_len = '0; bus_a.i_data = '0;
        bus_b.i_start = 1'b0; bus_b.i_len = '0; bus_b.i_data = '0;
        repeat (3) @(negedge clk);
        check("reset_idle_a", {bus_a.o_csb, bus_a.o_sclk, bus_a.o_mosi, bus_a.o_busy, bus_a.o_done}, 5'b10000);
        check("reset_idle_b", {bus_b.o_csb, bus_b.o_sclk, bus_b.o_mosi, bus_b.o_busy, bus_b.o_done}, 5'b10000);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            cur = vt[v].sel;
            start_frame(vt[v].len, vt[v].data);
            measure(1000, -1, 0, 7'd0, '0, busy_c, csb_c, edges, cap, viol, tail);
            check($sformatf("v%0d_busy_cycles", v), busy_c, vt[v].busy);
            check($sformatf("v%0d_csb_low", v), csb_c, vt[v].csb);
            check($sformatf("v%0d_edges", v), edges, vt[v].edges);
            check($sformatf("v%0d_payload", v), cap, order(vt[v].cap, vt[v].edges));
            check($sformatf("v%0d_mode0", v), viol, 0);
            @(negedge clk);
            check($sformatf("v%0d_idle_after", v), {m_busy, m_done, m_csb}, 3'b001);
        end

        // Zero-length request must leave every output idle
        cur = 0;
        start_frame(7'd0, {MB{1'b1}});
        any_busy = 0; any_csb = 0; any_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (m_busy) any_busy = 1;
            if (!m_csb) any_csb = 1;
            if (m_done) any_done = 1;
            @(negedge clk);
        end
        check("len0_busy", any_busy, 0);
        check("len0_csb", any_csb, 0);
        check("len0_done", any_done, 0);

        // Start mid-frame is ignored; start during o_done chains a new frame
        cur = 0;
        start_frame(7'd8, 96'hA5);
        measure(200, 10, 1, 7'd8, 96'h3C, busy_c, csb_c, edges, cap, viol, tail);
        check("midstart_busy", busy_c, 36);
        check("midstart_payload", cap, order(128'hA5, 8));
        check("chain_gap", tail, 3);
        @(negedge clk);
        drive(1'b0, 7'd8, 96'h3C);
        check("chain_setup_next", {m_busy, m_csb}, 2'b10);
        measure(200, -1, 0, 7'd0, '0, busy_c, csb_c, edges, cap, viol, tail);
        check("chain_busy", busy_c, 36);
        check("chain_payload", cap, order(128'h3C, 8));
        check("chain_edges", edges, 8);

        // Reset after three rising edges aborts the frame with no o_done
        cur = 0;
        start_frame(7'd8, 96'hA5);
        edges = 0;
        begin
            logic ps;
            int c;
            ps = 1'b0;
            for (c = 0; c < 100 && edges < 3; c++) begin
                if (m_sclk && !ps) edges++;
                ps = m_sclk;
                if (edges < 3) @(negedge clk);
            end
        end
        check("abort_reached_edges", edges, 3);
        reset = 1'b1;
        #1;
        check("abort_async_idle", {bus_a.o_csb, bus_a.o_sclk, bus_a.o_mosi, bus_a.o_busy, bus_a.o_done}, 5'b10000);
        @(negedge clk);
        reset = 1'b0;
        any_done = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_done || m_busy) any_done = 1;
            @(negedge clk);
        end
        check("abort_no_done", any_done, 0);
        start_frame(7'd8, 96'h81);
        measure(200, -1, 0, 7'd0, '0, busy_c, csb_c, edges, cap, viol, tail);
        check("after_abort_busy", busy_c, 36);
        check("after_abort_payload", cap, order(128'h81, 8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
